// File: rtl/seq_chk_pkg.sv
// Shared definitions for the sequence-repetition checker: per-channel FSM states,
// mode encoding and the saturating counter increment.
package seq_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ANT,
        ST_GAP,
        ST_CON
    } chk_state_e;

    localparam logic MODE_IMPL   = 1'b0;
    localparam logic MODE_FOLLOW = 1'b1;

    // Phase counter width: covers ANT_LEN-1, CON_LEN-1 and GAP-2 at their maxima.
    localparam int PH_W = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] top;
        top = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= top) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_rep_chan.sv
// One checker channel: antecedent/gap/consequent FSM, registered verdict pulses and
// saturating verdict counters. SEQ_REP_CHECKER_VAC_CNT_EN adds the vacuous counter.
module seq_rep_chan
    import seq_chk_pkg::*;
#(
    parameter int ANT_LEN = 2,
    parameter int CON_LEN = 2,
    parameter int GAP     = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             clr,
    input  logic             trig,
    input  logic             resp,
    output logic             pass_o,
    output logic             fail_o,
    output logic             vac_o,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
    ,
    output logic [CNT_W-1:0] vac_cnt
`endif
);

    chk_state_e      state, state_n;
    logic [PH_W-1:0] ph, ph_n;
    logic            mode_q, mode_n;
    logic            pass_d, fail_d, vac_d;
    logic            ant_done;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_n  = state;
        ph_n     = ph;
        mode_n   = mode_q;
        pass_d   = 1'b0;
        fail_d   = 1'b0;
        vac_d    = 1'b0;
        ant_done = 1'b0;

        if (!en) begin
            state_n = ST_IDLE;
            ph_n    = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (trig) begin
                        mode_n = mode;
                        ph_n   = PH_W'(1);
                        if (ANT_LEN == 1) ant_done = 1'b1;
                        else              state_n  = ST_ANT;
                    end
                end
                ST_ANT: begin
                    if (!trig) begin
                        state_n = ST_IDLE;
                        ph_n    = '0;
                        if (mode_q == MODE_FOLLOW) fail_d = 1'b1;
                        else                       vac_d  = 1'b1;
                    end else if (ph == PH_W'(ANT_LEN - 1)) begin
                        ant_done = 1'b1;
                    end else begin
                        ph_n = ph + 1'b1;
                    end
                end
                // GAP state spans GAP-1 ignored samples; the next sample is consequent cycle 1.
                ST_GAP: begin
                    if (ph == PH_W'(GAP - 2)) begin
                        state_n = ST_CON;
                        ph_n    = '0;
                    end else begin
                        ph_n = ph + 1'b1;
                    end
                end
                ST_CON: begin
                    if (!resp) begin
                        fail_d  = 1'b1;
                        state_n = ST_IDLE;
                        ph_n    = '0;
                    end else if (ph == PH_W'(CON_LEN - 1)) begin
                        pass_d  = 1'b1;
                        state_n = ST_IDLE;
                        ph_n    = '0;
                    end else begin
                        ph_n = ph + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    ph_n    = '0;
                end
            endcase

            // Last antecedent sample: with no gap it is also consequent cycle 1.
            if (ant_done) begin
                ph_n = '0;
                if (GAP == 0) begin
                    if (!resp) begin
                        fail_d  = 1'b1;
                        state_n = ST_IDLE;
                    end else if (CON_LEN == 1) begin
                        pass_d  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_CON;
                        ph_n    = PH_W'(1);
                    end
                end else if (GAP == 1) begin
                    state_n = ST_CON;
                end else begin
                    state_n = ST_GAP;
                end
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            ph     <= '0;
            mode_q <= MODE_IMPL;
            pass_o <= 1'b0;
            fail_o <= 1'b0;
            vac_o  <= 1'b0;
        end else begin
            state  <= state_n;
            ph     <= ph_n;
            mode_q <= mode_n;
            pass_o <= pass_d;
            fail_o <= fail_d;
            vac_o  <= vac_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            if (pass_d) pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_W));
            if (fail_d) fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
        end
    end

`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        vac_cnt <= '0;
        else if (clr)    vac_cnt <= '0;
        else if (vac_d)  vac_cnt <= CNT_W'(sat_inc(32'(vac_cnt), CNT_W));
    end
`endif

endmodule

// File: rtl/seq_rep_checker.sv
// Multi-channel sequence-repetition checker: NCH independent seq_rep_chan instances.
// Define SEQ_REP_CHECKER_VAC_CNT_EN to add the packed vac_cnt output.
module seq_rep_checker
    import seq_chk_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int ANT_LEN = 2,
    parameter int CON_LEN = 2,
    parameter int GAP     = 1,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 clr,
    input  logic [NCH-1:0]       trig,
    input  logic [NCH-1:0]       resp,
    output logic [NCH-1:0]       pass_o,
    output logic [NCH-1:0]       fail_o,
    output logic [NCH-1:0]       vac_o,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
    ,
    output logic [NCH*CNT_W-1:0] vac_cnt
`endif
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        seq_rep_chan #(
            .ANT_LEN(ANT_LEN),
            .CON_LEN(CON_LEN),
            .GAP    (GAP),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .mode    (mode),
            .clr     (clr),
            .trig    (trig[i]),
            .resp    (resp[i]),
            .pass_o  (pass_o[i]),
            .fail_o  (fail_o[i]),
            .vac_o   (vac_o[i]),
            .pass_cnt(pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt(fail_cnt[i*CNT_W +: CNT_W])
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
            ,
            .vac_cnt (vac_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_seq_rep_checker.sv
// Bench for seq_rep_checker: four parameter variants share one stimulus stream and are
// compared each cycle against an attempt-position reference model.
module tb_seq_rep_checker;

    localparam int NCFG = 4;
    localparam int NCH  = 4;
    localparam int AL[NCFG] = '{2, 2, 2, 1};
    localparam int GL[NCFG] = '{1, 0, 1, 3};
    localparam int CL[NCFG] = '{2, 2, 2, 3};
    localparam int WL[NCFG] = '{8, 8, 2, 8};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0, mode = 1'b0, clr = 1'b0;
    logic [NCH-1:0] trig = '0, resp = '0;

    logic [NCH-1:0] po[NCFG], fo[NCFG], vo[NCFG];
    logic [31:0]    pc0, fc0, pc1, fc1, pc3, fc3;
    logic [7:0]     pc2, fc2;
    int             obs_p[NCFG][NCH], obs_f[NCFG][NCH];
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
    logic [31:0]    vc0, vc1, vc3;
    logic [7:0]     vc2;
    int             obs_v[NCFG][NCH];
    int             m_vc[NCFG][NCH];
`endif

    always #5 clk = ~clk;

    seq_rep_checker #(.NCH(4), .ANT_LEN(2), .CON_LEN(2), .GAP(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .trig(trig), .resp(resp),
        .pass_o(po[0]), .fail_o(fo[0]), .vac_o(vo[0]), .pass_cnt(pc0), .fail_cnt(fc0)
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
        , .vac_cnt(vc0)
`endif
    );
    seq_rep_checker #(.NCH(4), .ANT_LEN(2), .CON_LEN(2), .GAP(0), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .trig(trig), .resp(resp),
        .pass_o(po[1]), .fail_o(fo[1]), .vac_o(vo[1]), .pass_cnt(pc1), .fail_cnt(fc1)
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
        , .vac_cnt(vc1)
`endif
    );
    seq_rep_checker #(.NCH(4), .ANT_LEN(2), .CON_LEN(2), .GAP(1), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .trig(trig), .resp(resp),
        .pass_o(po[2]), .fail_o(fo[2]), .vac_o(vo[2]), .pass_cnt(pc2), .fail_cnt(fc2)
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
        , .vac_cnt(vc2)
`endif
    );
    seq_rep_checker #(.NCH(4), .ANT_LEN(1), .CON_LEN(3), .GAP(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .trig(trig), .resp(resp),
        .pass_o(po[3]), .fail_o(fo[3]), .vac_o(vo[3]), .pass_cnt(pc3), .fail_cnt(fc3)
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
        , .vac_cnt(vc3)
`endif
    );

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            obs_p[0][ch] = int'(pc0[ch*8 +: 8]);  obs_f[0][ch] = int'(fc0[ch*8 +: 8]);
            obs_p[1][ch] = int'(pc1[ch*8 +: 8]);  obs_f[1][ch] = int'(fc1[ch*8 +: 8]);
            obs_p[2][ch] = int'(pc2[ch*2 +: 2]);  obs_f[2][ch] = int'(fc2[ch*2 +: 2]);
            obs_p[3][ch] = int'(pc3[ch*8 +: 8]);  obs_f[3][ch] = int'(fc3[ch*8 +: 8]);
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
            obs_v[0][ch] = int'(vc0[ch*8 +: 8]);  obs_v[1][ch] = int'(vc1[ch*8 +: 8]);
            obs_v[2][ch] = int'(vc2[ch*2 +: 2]);  obs_v[3][ch] = int'(vc3[ch*8 +: 8]);
`endif
        end
    end

    // Reference model: an attempt is a position k counted from its first trig sample.
    bit m_act[NCFG][NCH];
    int m_k[NCFG][NCH];
    bit m_mode[NCFG][NCH];
    bit m_p[NCFG][NCH], m_f[NCFG][NCH], m_v[NCFG][NCH];
    int m_pc[NCFG][NCH], m_fc[NCFG][NCH];

    int n_checks = 0;
    int n_fail   = 0;

    logic [NCH-1:0] hp[NCFG][40], hf[NCFG][40], hv[NCFG][40];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        return (v >= (1 << w) - 1) ? v : v + 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++)
            for (int ch = 0; ch < NCH; ch++) begin
                m_act[c][ch] = 0; m_k[c][ch] = 0; m_mode[c][ch] = 0;
                m_p[c][ch] = 0; m_f[c][ch] = 0; m_v[c][ch] = 0;
                m_pc[c][ch] = 0; m_fc[c][ch] = 0;
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
                m_vc[c][ch] = 0;
`endif
            end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCFG; c++)
            for (int ch = 0; ch < NCH; ch++) begin
                bit sampled;
                int c0;
                m_p[c][ch] = 0; m_f[c][ch] = 0; m_v[c][ch] = 0;
                sampled = 0;
                if (!en) begin
                    m_act[c][ch] = 0;
                end else if (!m_act[c][ch]) begin
                    if (trig[ch]) begin
                        m_act[c][ch] = 1; m_k[c][ch] = 0; m_mode[c][ch] = mode; sampled = 1;
                    end
                end else begin
                    m_k[c][ch]++;
                    sampled = 1;
                end
                if (sampled) begin
                    c0 = AL[c] - 1 + GL[c];
                    if (m_k[c][ch] < AL[c] && !trig[ch]) begin
                        if (m_mode[c][ch]) m_f[c][ch] = 1;
                        else               m_v[c][ch] = 1;
                    end else if (m_k[c][ch] >= c0) begin
                        if (!resp[ch])                         m_f[c][ch] = 1;
                        else if (m_k[c][ch] == c0 + CL[c] - 1) m_p[c][ch] = 1;
                    end
                    if (m_p[c][ch] || m_f[c][ch] || m_v[c][ch]) m_act[c][ch] = 0;
                end
                if (clr) begin
                    m_pc[c][ch] = 0; m_fc[c][ch] = 0;
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
                    m_vc[c][ch] = 0;
`endif
                end else begin
                    if (m_p[c][ch]) m_pc[c][ch] = sat(m_pc[c][ch], WL[c]);
                    if (m_f[c][ch]) m_fc[c][ch] = sat(m_fc[c][ch], WL[c]);
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
                    if (m_v[c][ch]) m_vc[c][ch] = sat(m_vc[c][ch], WL[c]);
`endif
                end
            end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCFG; c++)
            for (int ch = 0; ch < NCH; ch++) begin
                check($sformatf("cfg%0d ch%0d pass_o", c, ch), int'(po[c][ch]), int'(m_p[c][ch]));
                check($sformatf("cfg%0d ch%0d fail_o", c, ch), int'(fo[c][ch]), int'(m_f[c][ch]));
                check($sformatf("cfg%0d ch%0d vac_o", c, ch), int'(vo[c][ch]), int'(m_v[c][ch]));
                check($sformatf("cfg%0d ch%0d pass_cnt", c, ch), obs_p[c][ch], m_pc[c][ch]);
                check($sformatf("cfg%0d ch%0d fail_cnt", c, ch), obs_f[c][ch], m_fc[c][ch]);
`ifdef SEQ_REP_CHECKER_VAC_CNT_EN
                check($sformatf("cfg%0d ch%0d vac_cnt", c, ch), obs_v[c][ch], m_vc[c][ch]);
`endif
            end
    endtask

    // Inputs change on the falling edge; outputs are checked one falling edge later.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Called on a falling edge; asserts reset asynchronously mid-low-phase.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Bit i of each vector applies to cycle i+1; hp/hf/hv[cfg][n] hold outputs seen in cycle n.
    task automatic run_pat(input logic [31:0] t0, input logic [31:0] r0,
                           input logic [31:0] t3, input logic [31:0] r3,
                           input logic [31:0] ev, input logic m, input int n, input int rc);
        for (int c = 0; c < NCFG; c++)
            for (int y = 0; y < 40; y++) begin
                hp[c][y] = '0; hf[c][y] = '0; hv[c][y] = '0;
            end
        mode = m;
        clr  = 1'b0;
        for (int i = 1; i <= n; i++) begin
            trig = {t3[i-1], 2'b00, t0[i-1]};
            resp = {r3[i-1], 2'b00, r0[i-1]};
            en   = ev[i-1];
            if (i == rc) async_reset();
            tick();
            for (int c = 0; c < NCFG; c++) begin
                hp[c][i+1] = po[c]; hf[c][i+1] = fo[c]; hv[c][i+1] = vo[c];
            end
        end
        trig = '0; resp = '0; en = 1'b1;
    endtask

    initial begin
        logic [31:0] tv, rv;
        int quiet;

        model_reset();
        #2 rst = 1'b0;
        #1 compare_all();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;

        // Basic pass with default timing.
        run_pat(32'b110, 32'b11000, '0, '0, '1, 1'b0, 8, 0);
        check("basic pass_o at cycle 6", int'(hp[0][6][0]), 1);
        check("basic pass_cnt", obs_p[0][0], 1);

        // Short antecedent: vacuous in mode 0, fail in mode 1.
        async_reset();
        run_pat(32'b10, '0, '0, '0, '1, 1'b0, 6, 0);
        check("short ant vac_o at cycle 4", int'(hv[0][4][0]), 1);
        check("short ant pass_cnt unchanged", obs_p[0][0], 0);
        check("short ant fail_cnt unchanged", obs_f[0][0], 0);
        async_reset();
        run_pat(32'b10, '0, '0, '0, '1, 1'b1, 6, 0);
        check("followed-by fail_o at cycle 4", int'(hf[0][4][0]), 1);
        check("followed-by fail_cnt", obs_f[0][0], 1);

        // Overlapped consequent (GAP=0 variant).
        async_reset();
        run_pat(32'b110, 32'b1100, '0, '0, '1, 1'b0, 7, 0);
        check("gap0 pass_o at cycle 5", int'(hp[1][5][0]), 1);
        async_reset();
        run_pat(32'b110, 32'b0100, '0, '0, '1, 1'b0, 7, 0);
        check("gap0 fail_o at cycle 5", int'(hf[1][5][0]), 1);

        // Five back-to-back passes, then clear.
        async_reset();
        tv = '0; rv = '0;
        for (int a = 0; a < 5; a++) begin
            tv[4*a+1] = 1'b1; tv[4*a+2] = 1'b1;
            rv[4*a+3] = 1'b1; rv[4*a+4] = 1'b1;
        end
        run_pat(tv, rv, '0, '0, '1, 1'b0, 23, 0);
        check("cnt_w2 pass_cnt saturated", obs_p[2][0], 3);
        check("cnt_w8 pass_cnt five", obs_p[0][0], 5);
        clr = 1'b1;
        tick();
        check("clr zeroes pass_cnt", obs_p[2][0], 0);
        clr = 1'b0;

        // Reset during the consequent discards the attempt.
        run_pat(32'b110, 32'b11000, '0, '0, '1, 1'b0, 7, 5);
        quiet = 0;
        for (int y = 0; y < 40; y++) quiet |= int'(hp[0][y][0]);
        check("reset in CON no pass_o", quiet, 0);
        check("reset in CON pass_cnt", obs_p[0][0], 0);

        // en low during the gap; a later trigger starts a fresh attempt.
        async_reset();
        run_pat(32'b10010, 32'b1110000000, '0, '0, ~32'b100, 1'b0, 12, 0);
        quiet = 0;
        for (int y = 3; y <= 10; y++) quiet |= int'(hp[3][y][0] | hf[3][y][0] | hv[3][y][0]);
        check("en low no verdict", quiet, 0);
        check("en restored pass_o at cycle 11", int'(hp[3][11][0]), 1);

        // Simultaneous verdicts on channels 0 and 3.
        async_reset();
        run_pat(32'b110, 32'b11000, 32'b1000, '0, '1, 1'b0, 8, 0);
        check("ch0 pass_o at cycle 6", int'(hp[0][6][0]), 1);
        check("ch3 vac_o at cycle 6", int'(hv[0][6][3]), 1);
        check("ch1-2 idle at cycle 6", int'(hp[0][6][2:1] | hf[0][6][2:1] | hv[0][6][2:1]), 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                trig[ch] = ($urandom_range(0, 99) < 55);
                resp[ch] = ($urandom_range(0, 99) < 75);
            end
            en  = ($urandom_range(0, 99) < 95);
            clr = en && ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 10) mode = ~mode;
            if ($urandom_range(0, 199) == 0) async_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_rep_checker.md
SEQ_REP_CHECKER -- requirements
Module: seq_rep_checker

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent channels (1..16).
REQ-002 SHALL have parameter ANT_LEN, default 2, meaning consecutive trigger cycles forming the antecedent (1..15).
REQ-003 SHALL have parameter CON_LEN, default 2, meaning consecutive response cycles forming the consequent (1..15).
REQ-004 SHALL have parameter GAP, default 1, meaning cycles from last antecedent sample to first consequent sample (0 = overlapped, same sample; 0..7).
REQ-005 SHALL have parameter CNT_W, default 8, meaning width of the per-channel verdict counters.
REQ-006 SHALL have port clk, input, 1, the single clock; all sampling on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port en, input, 1, global checker enable.
REQ-009 SHALL have port mode, input, 1: 0 = implication, 1 = followed-by.
REQ-010 SHALL have port clr, input, 1, synchronous clear of all counters.
REQ-011 SHALL have port trig, input, NCH, per-channel antecedent signal.
REQ-012 SHALL have port resp, input, NCH, per-channel consequent signal.
REQ-013 SHALL have port pass_o, output, NCH, one-cycle pass pulse.
REQ-014 SHALL have port fail_o, output, NCH, one-cycle fail pulse.
REQ-015 SHALL have port vac_o, output, NCH, one-cycle vacuous pulse (implication mode only).
REQ-016 SHALL have port pass_cnt, output, NCH*CNT_W, packed per-channel pass counts; channel i at [i*CNT_W +: CNT_W].
REQ-017 SHALL have port fail_cnt, output, NCH*CNT_W, packed per-channel fail counts, same packing.

Function
REQ-018 Each channel SHALL run an FSM: IDLE, ANT, GAP, CON.
REQ-019 IDLE -> ANT on first sampled trig=1; that sample counts as antecedent cycle 1.
REQ-020 In ANT, trig=0 before ANT_LEN consecutive highs SHALL end the attempt: vacuous in mode 0, fail in mode 1; return to IDLE.
REQ-021 On the ANT_LEN-th high: GAP=0 -> the same sample is consequent cycle 1 (evaluate resp there); GAP>0 -> enter GAP for GAP cycles, then CON.
REQ-022 In CON, resp=0 on any sample SHALL yield fail and return to IDLE; CON_LEN consecutive highs SHALL yield pass and return to IDLE.
REQ-023 trig and resp SHALL be ignored in GAP; trig SHALL be ignored in CON (single attempt in flight per channel; no overlapping attempts).
REQ-024 Verdict pulses SHALL be registered and assert exactly one cycle after the deciding sample; at most one of pass_o/fail_o/vac_o per channel per cycle.
REQ-025 A channel returning to IDLE SHALL accept a new trig on the very next sample.
REQ-026 Counters SHALL increment on their pulse and saturate at 2^CNT_W-1.
REQ-027 clr SHALL zero counters next cycle; clr coincident with a pulse: clear wins.
REQ-028 en=0 SHALL force all FSMs to IDLE next cycle, suppress new pulses, and hold counters; an in-flight attempt is discarded with no verdict.
REQ-029 mode SHALL be sampled per attempt at IDLE->ANT; later changes affect only subsequent attempts.

Reset
REQ-030 rst low SHALL asynchronously force all FSMs to IDLE, all pulses to 0, all counters to 0.
REQ-031 Reset mid-attempt SHALL discard the attempt with no verdict.

Configuration
REQ-032 With SEQ_REP_CHECKER_VAC_CNT_EN defined, SHALL add output vac_cnt (NCH*CNT_W), counting vac_o with the same saturate/clear rules; without it, the port and its logic are absent and vac_o remains.

Structure
REQ-033 A shared package seq_chk_pkg SHALL hold the FSM state enum, mode encoding constants, and the saturating-increment function.
REQ-034 The per-channel FSM plus counters SHALL be a sub-module seq_rep_chan, instantiated NCH times via generate.

Verification
REQ-035 Defaults, mode 0: trig=1 cycles 2-3, resp=1 cycles 4-5 -> pass_o[0] pulse at cycle 6, pass_cnt[0]=1.
REQ-036 Defaults, mode 0: trig=1 cycle 2 only -> vac_o[0] pulse at cycle 4, counts unchanged; mode 1 same stimulus -> fail_o[0] at cycle 4, fail_cnt[0]=1.
REQ-037 GAP=0: trig=1 cycles 2-3, resp=1 cycles 3-4 -> pass at cycle 5; resp=0 at cycle 4 -> fail at cycle 5.
REQ-038 CNT_W=2: 5 consecutive passing attempts -> pass_cnt saturates at 3; clr pulse -> 0 next cycle.
REQ-039 rst low asynchronously during CON -> no pulse, counters 0; en=0 during GAP -> no verdict, channel accepts new trig after en=1.
REQ-040 NCH=4, independent stimulus per channel with simultaneous verdicts on channels 0 and 3 -> both pulses in the same cycle, other channels unaffected.
